// File: rtl/systolic_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
// Shared types and constants for the 3x3 systolic job controller.
//   state_t     : controller FSM states
//   N           : array dimension (rows = columns = 3)
//   RUN_CYCLES  : cycles ARR_START is held while wavefronts are streamed
//   LOAD_BEATS  : operand row beats per job (3 A rows then 3 B rows)
//   idx_ok()    : true when a skewed matrix index falls inside 0..N-1
// -----------------------------------------------------------------------------
package systolic_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      RUN,
      WAIT,
      CAPTURE,
      HOLD
   } state_t;

   localparam int N          = 3;
   localparam int RUN_CYCLES = 8;
   localparam int LOAD_BEATS = 6;

   function automatic logic idx_ok(input int k);
      return (k >= 0) && (k < N);
   endfunction

endpackage

// File: rtl/systolic_operand_skew.sv
// -----------------------------------------------------------------------------
// systolic_operand_skew
// Combinational wavefront generator. For run step t it produces the operands
// entering the array edges: row i gets A[i][t-i], column j gets B[t-j][j];
// any index outside 0..2 yields zero, so every operand is zero from t=5 on.
// Ports:
//   t      in  4           run step (values past the run give all zeros)
//   a_mat  in  9*DATAWIDTN stored A, element (r,c) at bit (r*3+c)*DATAWIDTN
//   b_mat  in  9*DATAWIDTN stored B, same packing
//   a_skew out 3*DATAWIDTN {A2,A1,A0} row operands
//   b_skew out 3*DATAWIDTN {B2,B1,B0} column operands
// -----------------------------------------------------------------------------
module systolic_operand_skew
   import systolic_pkg::*;
#(
   parameter int DATAWIDTN = 8
) (
   input  logic [3:0]                 t,
   input  logic [N*N*DATAWIDTN-1:0]   a_mat,
   input  logic [N*N*DATAWIDTN-1:0]   b_mat,
   output logic [N*DATAWIDTN-1:0]     a_skew,
   output logic [N*DATAWIDTN-1:0]     b_skew
);

   always_comb begin
      a_skew = '0;
      b_skew = '0;
      for (int i = 0; i < N; i++) begin
         // row i lags row 0 by i cycles; column j likewise
         if (idx_ok(int'(t) - i))
            a_skew[i*DATAWIDTN +: DATAWIDTN] = a_mat[(i*N + int'(t) - i)*DATAWIDTN +: DATAWIDTN];
         if (idx_ok(int'(t) - i))
            b_skew[i*DATAWIDTN +: DATAWIDTN] = b_mat[((int'(t) - i)*N + i)*DATAWIDTN +: DATAWIDTN];
      end
   end

endmodule

// File: rtl/systolic_job_ctrl.sv
// -----------------------------------------------------------------------------
// systolic_job_ctrl
// Sequencer for the 3x3 systolic multiply array. Loads A and B row by row,
// clears the array, streams skewed wavefronts with ARR_START held for the run,
// waits for ARR_DONE, snapshots P11..P33 and offers it on a valid/ready port.
// Optional build macro: SYSTOLIC_TIMEOUT_EN adds a WAIT timeout that sets the
// sticky ERR flag and abandons the job; without it ERR is tied low.
// Ports:
//   CLK, RST                  clock, synchronous active-high reset
//   IN_VALID/IN_READY/IN_DATA operand row beats {col2,col1,col0}; A rows, then B
//   ARR_RSTn, ARR_START       array reset (active-low, registered) and start
//   ARR_A0..2, ARR_B0..2      registered skewed operands to the array
//   ARR_P, ARR_DONE           array products {P33..P11} and done flag
//   RES_VALID/RES_READY/RES_DATA captured 3x3 product, same packing as ARR_P
//   BUSY                      high outside IDLE
//   ERR                       sticky WAIT timeout
// -----------------------------------------------------------------------------
module systolic_job_ctrl
   import systolic_pkg::*;
#(
   parameter int DATAWIDTN   = 8,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic                          IN_VALID,
   output logic                          IN_READY,
   input  logic [N*DATAWIDTN-1:0]        IN_DATA,
   output logic                          ARR_RSTn,
   output logic                          ARR_START,
   output logic [DATAWIDTN-1:0]          ARR_A0,
   output logic [DATAWIDTN-1:0]          ARR_A1,
   output logic [DATAWIDTN-1:0]          ARR_A2,
   output logic [DATAWIDTN-1:0]          ARR_B0,
   output logic [DATAWIDTN-1:0]          ARR_B1,
   output logic [DATAWIDTN-1:0]          ARR_B2,
   input  logic [N*N*2*DATAWIDTN-1:0]    ARR_P,
   input  logic                          ARR_DONE,
   output logic                          RES_VALID,
   input  logic                          RES_READY,
   output logic [N*N*2*DATAWIDTN-1:0]    RES_DATA,
   output logic                          BUSY,
   output logic                          ERR
);

   localparam int DW = DATAWIDTN;

   state_t                  state;
   logic [2:0]              beat_cnt;
   logic [3:0]              run_t;
   logic [N*N*DW-1:0]       a_mat;
   logic [N*N*DW-1:0]       b_mat;
   logic [3:0]              skew_t;
   logic [N*DW-1:0]         a_skew;
   logic [N*DW-1:0]         b_skew;
   logic [N*DW-1:0]         a_op_p1;
   logic [N*DW-1:0]         b_op_p1;
`ifdef SYSTOLIC_TIMEOUT_EN
   logic [15:0]             wait_cnt;
   logic                    err_q;
`endif

   assign IN_READY  = (state == IDLE);
   assign BUSY      = (state != IDLE);
   assign RES_VALID = (state == HOLD);

`ifdef SYSTOLIC_TIMEOUT_EN
   assign ERR = err_q;
`else
   assign ERR = 1'b0;
`endif

   assign ARR_A0 = a_op_p1[0*DW +: DW];
   assign ARR_A1 = a_op_p1[1*DW +: DW];
   assign ARR_A2 = a_op_p1[2*DW +: DW];
   assign ARR_B0 = b_op_p1[0*DW +: DW];
   assign ARR_B1 = b_op_p1[1*DW +: DW];
   assign ARR_B2 = b_op_p1[2*DW +: DW];

   // Operands are registered one step ahead: CLEAR prepares t=0, RUN step t
   // prepares t+1 (t+1 = 8 falls outside the matrices and yields zeros).
   assign skew_t = (state == CLEAR) ? 4'd0 : run_t + 4'd1;

   systolic_operand_skew #(
      .DATAWIDTN (DATAWIDTN)
   ) u_skew (
      .t      (skew_t),
      .a_mat  (a_mat),
      .b_mat  (b_mat),
      .a_skew (a_skew),
      .b_skew (b_skew)
   );

   // ---- operand store (data only, no reset) ----
   always_ff @(posedge CLK) begin
      if (state == IDLE && IN_VALID) begin
         if (beat_cnt < 3'(N))
            a_mat[int'(beat_cnt)*N*DW +: N*DW] <= IN_DATA;
         else
            b_mat[(int'(beat_cnt) - N)*N*DW +: N*DW] <= IN_DATA;
      end
   end

   // ---- control FSM and registered array/result outputs ----
   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         beat_cnt  <= '0;
         run_t     <= '0;
         ARR_RSTn  <= 1'b0;
         ARR_START <= 1'b0;
         a_op_p1   <= '0;
         b_op_p1   <= '0;
         RES_DATA  <= '0;
`ifdef SYSTOLIC_TIMEOUT_EN
         wait_cnt  <= '0;
         err_q     <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               ARR_RSTn <= 1'b1;
               if (IN_VALID) begin
                  if (beat_cnt == 3'(LOAD_BEATS - 1)) begin
                     beat_cnt <= '0;
                     ARR_RSTn <= 1'b0;
                     state    <= CLEAR;
                  end else begin
                     beat_cnt <= beat_cnt + 3'd1;
                  end
               end
            end
            CLEAR: begin
               ARR_RSTn  <= 1'b1;
               ARR_START <= 1'b1;
               a_op_p1   <= a_skew;
               b_op_p1   <= b_skew;
               run_t     <= '0;
               state     <= RUN;
            end
            RUN: begin
               a_op_p1 <= a_skew;
               b_op_p1 <= b_skew;
               if (run_t == 4'(RUN_CYCLES - 1)) begin
                  ARR_START <= 1'b0;
                  state     <= WAIT;
`ifdef SYSTOLIC_TIMEOUT_EN
                  wait_cnt  <= '0;
`endif
               end else begin
                  run_t <= run_t + 4'd1;
               end
            end
            WAIT: begin
               if (ARR_DONE) begin
                  state <= CAPTURE;
`ifdef SYSTOLIC_TIMEOUT_EN
               end else if (wait_cnt == 16'(TIMEOUT_CYC - 1)) begin
                  err_q <= 1'b1;
                  state <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt + 16'd1;
`endif
               end
            end
            CAPTURE: begin
               // array P registers settle one cycle after ARR_DONE
               RES_DATA <= ARR_P;
               state    <= HOLD;
            end
            HOLD: begin
               if (RES_READY)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_systolic_job_ctrl.sv
module tb_systolic_job_ctrl;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [23:0]   in_data;
   logic          arr_rstn;
   logic          arr_start;
   logic [7:0]    a0, a1, a2, b0, b1, b2;
   logic [143:0]  arr_p;
   logic          arr_done;
   logic          res_valid;
   logic          res_ready;
   logic [143:0]  res_data;
   logic          busy;
   logic          err;

   always #5 clk = ~clk;

   systolic_job_ctrl #(
      .DATAWIDTN   (8),
      .TIMEOUT_CYC (16)
   ) dut (
      .CLK       (clk),
      .RST       (rst),
      .IN_VALID  (in_valid),
      .IN_READY  (in_ready),
      .IN_DATA   (in_data),
      .ARR_RSTn  (arr_rstn),
      .ARR_START (arr_start),
      .ARR_A0    (a0),
      .ARR_A1    (a1),
      .ARR_A2    (a2),
      .ARR_B0    (b0),
      .ARR_B1    (b1),
      .ARR_B2    (b2),
      .ARR_P     (arr_p),
      .ARR_DONE  (arr_done),
      .RES_VALID (res_valid),
      .RES_READY (res_ready),
      .RES_DATA  (res_data),
      .BUSY      (busy),
      .ERR       (err)
   );

   // ---------------- behavioural 3x3 output-stationary array ----------------
   logic [7:0]  ain [3][3];
   logic [7:0]  bin [3][3];
   logic [7:0]  pa  [3][3];
   logic [7:0]  pb  [3][3];
   logic [15:0] acc [3][3];
   logic [3:0]  acnt;
   logic        stall_done;

   always_comb begin
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++) begin
            ain[i][j] = '0;
            bin[i][j] = '0;
         end
      ain[0][0] = a0; ain[1][0] = a1; ain[2][0] = a2;
      bin[0][0] = b0; bin[0][1] = b1; bin[0][2] = b2;
      for (int i = 0; i < 3; i++)
         for (int j = 1; j < 3; j++)
            ain[i][j] = pa[i][j-1];
      for (int i = 1; i < 3; i++)
         for (int j = 0; j < 3; j++)
            bin[i][j] = pb[i-1][j];
   end

   always @(posedge clk) begin
      if (!arr_rstn) begin
         for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
               pa[i][j]  <= '0;
               pb[i][j]  <= '0;
               acc[i][j] <= '0;
            end
         acnt  <= '0;
         arr_p <= '0;
      end else begin
         for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
               pa[i][j]  <= ain[i][j];
               pb[i][j]  <= bin[i][j];
               acc[i][j] <= acc[i][j] + 16'(ain[i][j]) * 16'(bin[i][j]);
               arr_p[(i*3+j)*16 +: 16] <= acc[i][j];
            end
         if (arr_start) acnt <= acnt + 4'd1;
      end
   end

   assign arr_done = (acnt == 4'd8) && !stall_done;

   // ---------------- checking and scoreboard ----------------
   int total = 0;
   int bad   = 0;
   int nres  = 0;
   int npush = 0;
   int startcyc = 0;
   logic [143:0] sb [$];

   task automatic chk(input string tag, input logic [143:0] got, input logic [143:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   function automatic logic [143:0] matmul(input logic [71:0] a, input logic [71:0] b);
      logic [143:0] r;
      logic [15:0]  s;
      r = '0;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++) begin
            s = '0;
            for (int k = 0; k < 3; k++)
               s = s + 16'(a[(i*3+k)*8 +: 8]) * 16'(b[(k*3+j)*8 +: 8]);
            r[(i*3+j)*16 +: 16] = s;
         end
      return r;
   endfunction

   task automatic push_exp(input logic [143:0] want);
      sb.push_back(want);
      npush++;
   endtask

   initial forever begin
      @(negedge clk);
      if (arr_start) startcyc++;
      if (res_valid && res_ready) begin
         chk("sb_has_exp", 144'(sb.size() != 0), 144'd1);
         if (sb.size() != 0) chk("res_data", res_data, sb.pop_front());
         nres++;
      end
   end

   task automatic send_job(input logic [71:0] a, input logic [71:0] b);
      for (int bt = 0; bt < 6; bt++) begin
         int w;
         in_valid = 1'b1;
         in_data  = (bt < 3) ? a[bt*24 +: 24] : b[(bt-3)*24 +: 24];
         w = 0;
         while (!in_ready && w < 100) begin
            @(posedge clk); #1;
            w++;
         end
         if (w >= 100) chk("beat_accept_timeout", 144'(in_ready), 144'd1);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int cyc);
      cyc = -1;
      for (int k = 1; k <= 100; k++) begin
         @(posedge clk); #1;
         if (res_valid) begin
            cyc = k;
            return;
         end
      end
   endtask

   task automatic take_result();
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
   endtask

   localparam logic [71:0]  M_ID  = 72'h010000000100000001;
   localparam logic [71:0]  M_B   = 72'h090807060504030201;
   localparam logic [71:0]  M_FF  = {9{8'hFF}};
   localparam logic [143:0] P_1_9 = {16'd9, 16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
   localparam logic [143:0] P_FF  = {9{16'hFA03}};

   initial begin
      int cyc;
      int instab;
      logic [95:0]  rnd;
      logic [71:0]  ra, rb;
      logic [143:0] snap;

      rst = 1'b1; in_valid = 1'b0; in_data = '0; res_ready = 1'b0; stall_done = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready",  144'(in_ready),  144'd1);
      chk("rst_busy",      144'(busy),      144'd0);
      chk("rst_arr_rstn",  144'(arr_rstn),  144'd0);
      chk("rst_arr_start", 144'(arr_start), 144'd0);
      chk("rst_operands",  144'({a0, a1, a2, b0, b1, b2}), 144'd0);
      chk("rst_res_valid", 144'(res_valid), 144'd0);
      chk("rst_res_data",  res_data, 144'd0);
      chk("rst_err",       144'(err),       144'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("idle_arr_rstn", 144'(arr_rstn), 144'd1);

      // identity x B
      startcyc = 0;
      push_exp(matmul(M_ID, M_B));
      send_job(M_ID, M_B);
      wait_valid(cyc);
      chk("id_latency",   144'(cyc), 144'd11);
      chk("id_const",     res_data, P_1_9);
      chk("hold_in_ready", 144'(in_ready), 144'd0);
      chk("hold_busy",    144'(busy), 144'd1);
      chk("start_cycles", 144'(startcyc), 144'd8);
      take_result();
      chk("taken_valid",  144'(res_valid), 144'd0);
      chk("taken_ready",  144'(in_ready), 144'd1);
      chk("id_once",      144'(nres), 144'd1);

      // all 0xFF operands wrap to 0xFA03
      push_exp(matmul(M_FF, M_FF));
      send_job(M_FF, M_FF);
      wait_valid(cyc);
      chk("ff_const", res_data, P_FF);
      take_result();

      // back-to-back, ready held high early; second job must come out zero
      res_ready = 1'b1;
      rnd = {$urandom(), $urandom(), $urandom()};
      ra  = rnd[71:0];
      rnd = {$urandom(), $urandom(), $urandom()};
      rb  = rnd[71:0];
      push_exp(matmul(ra, rb));
      send_job(ra, rb);
      push_exp(matmul(72'd0, rb));
      send_job(72'd0, rb);
      wait_valid(cyc);
      chk("b2b_latency", 144'(cyc), 144'd11);
      chk("b2b_zero",    res_data, 144'd0);
      @(posedge clk); #1;
      res_ready = 1'b0;
      chk("b2b_released", 144'(res_valid), 144'd0);

      // long hold with ready low
      push_exp(matmul(M_B, M_ID));
      send_job(M_B, M_ID);
      wait_valid(cyc);
      snap = res_data;
      instab = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (!res_valid || res_data !== snap || in_ready) instab++;
      end
      chk("hold_stable", 144'(instab), 144'd0);
      chk("hold_data",   snap, P_1_9);
      take_result();

      // reset during RUN t=3 aborts, then a fresh job works
      send_job(M_FF, M_FF);
      repeat (4) begin @(posedge clk); #1; end
      chk("abort_pre_start", 144'(arr_start), 144'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_idle",     144'(in_ready),  144'd1);
      chk("abort_start",    144'(arr_start), 144'd0);
      chk("abort_arr_rstn", 144'(arr_rstn),  144'd0);
      chk("abort_busy",     144'(busy),      144'd0);
      push_exp(matmul(M_B, M_B));
      send_job(M_B, M_B);
      wait_valid(cyc);
      chk("fresh_latency", 144'(cyc), 144'd11);
      take_result();

`ifdef SYSTOLIC_TIMEOUT_EN
      begin
         int n0;
         int k;
         n0 = nres;
         stall_done = 1'b1;
         send_job(M_ID, M_B);
         k = 0;
         while (!err && k < 100) begin
            @(posedge clk); #1;
            k++;
         end
         chk("to_cycles",    144'(k), 144'd25);
         chk("to_idle",      144'(in_ready), 144'd1);
         chk("to_no_valid",  144'(nres - n0), 144'd0);
         stall_done = 1'b0;
         push_exp(matmul(M_ID, M_B));
         send_job(M_ID, M_B);
         wait_valid(cyc);
         chk("to_sticky",    144'(err), 144'd1);
         chk("to_recovered", res_data, P_1_9);
         take_result();
      end
`else
      chk("err_tied", 144'(err), 144'd0);
`endif

      repeat (2) @(posedge clk);
      #1;
      chk("sb_drained", 144'(sb.size()), 144'd0);
      chk("result_count", 144'(nres), 144'(npush));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
